mem_access_stage: RTL and testbench

Memory stage of the five-stage MIPS pipeline, downstream of the execute stage. Consumes the registered EX/MEM bundle (ALU result, store data, selected destination register, memory control), performs byte/half/word loads and stores against a variable-latency data memory through a request/acknowledge handshake, and stalls the pipeline until the access completes. Produces the registered MEM/WB bundle for write-back.

---
 rtl/mem_access_stage.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MIPS pipeline memory stage: byte/half/word loads and stores over a req/ack
// data-memory handshake, stalling upstream until the access completes.
module mem_access_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        EX_Valid,
  input  logic [31:0] EX_ALUResult,
  input  logic [31:0] EX_StoreData,
  input  logic [4:0]  EX_rDest,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic [1:0]  EX_MemSize,
  input  logic        EX_LoadSigned,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [3:0]  Mem_BE,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic        Stall,
  output logic        AlignErr,
  output logic        WB_Valid,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_rDest,
  output logic [31:0] WB_Data
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Request fields captured when the access has to wait for its ack
  logic [DATA_W-1:0] req_addr_q,     req_addr_d;
  logic              req_we_q,       req_we_d;
  logic [BE_W-1:0]   req_be_q,       req_be_d;
  logic [DATA_W-1:0] req_wdata_q,    req_wdata_d;
  logic [OFF_W-1:0]  req_off_q,      req_off_d;
  logic [SIZE_W-1:0] req_size_q,     req_size_d;
  logic              req_sgn_q,      req_sgn_d;
  logic [REG_W-1:0]  req_rdest_q,    req_rdest_d;
  logic              req_regwrite_q, req_regwrite_d;

  logic              wb_valid_q,    wb_valid_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [REG_W-1:0]  wb_rdest_q,    wb_rdest_d;
  logic [DATA_W-1:0] wb_data_q,     wb_data_d;

  logic [OFF_W-1:0]  ex_off;
  logic              ex_mem_op;
  logic              ex_aligned;
  logic [BE_W-1:0]   ex_be;
  logic [DATA_W-1:0] ex_wdata;

  logic [DATA_W-1:0] cur_addr;
  logic              cur_we;
  logic [BE_W-1:0]   cur_be;
  logic [DATA_W-1:0] cur_wdata;
  logic [OFF_W-1:0]  cur_off;
  logic [SIZE_W-1:0] cur_size;
  logic              cur_sgn;
  logic [REG_W-1:0]  cur_rdest;
  logic              cur_regwrite;

  logic mem_req_c;
  logic stall_c;
  logic align_err_c;
  logic complete_c;

  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] rdata,
    input logic [OFF_W-1:0]  off,
    input logic [SIZE_W-1:0] size,
    input logic              sgn
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Lane placement and alignment of the incoming EX access
  always_comb begin : ex_decode
    ex_off    = EX_ALUResult[1:0];
    ex_mem_op = EX_MemRead | EX_MemWrite;
    case (EX_MemSize)
      2'b00: begin
        ex_aligned = 1'b1;
        ex_be      = BE_W'(4'b0001 << ex_off);
        ex_wdata   = {4{EX_StoreData[7:0]}};
      end
      2'b01: begin
        ex_aligned = ~ex_off[0];
        ex_be      = BE_W'(4'b0011 << ex_off);
        ex_wdata   = {2{EX_StoreData[15:0]}};
      end
      default: begin
        ex_aligned = (ex_off == 2'b00);
        ex_be      = 4'b1111;
        ex_wdata   = EX_StoreData;
      end
    endcase
  end

  // Live fields come from EX in IDLE and from the capture registers in WAIT
  always_comb begin : req_fields
    if (state_q == ST_WAIT) begin
      cur_addr     = req_addr_q;
      cur_we       = req_we_q;
      cur_be       = req_be_q;
      cur_wdata    = req_wdata_q;
      cur_off      = req_off_q;
      cur_size     = req_size_q;
      cur_sgn      = req_sgn_q;
      cur_rdest    = req_rdest_q;
      cur_regwrite = req_regwrite_q;
    end else begin
      cur_addr     = {EX_ALUResult[31:2], 2'b00};
      cur_we       = EX_MemWrite;
      cur_be       = ex_be;
      cur_wdata    = ex_wdata;
      cur_off      = ex_off;
      cur_size     = EX_MemSize;
      cur_sgn      = EX_LoadSigned;
      cur_rdest    = EX_rDest;
      cur_regwrite = EX_RegWrite;
    end
  end

  always_comb begin : next_state
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    req_we_d       = req_we_q;
    req_be_d       = req_be_q;
    req_wdata_d    = req_wdata_q;
    req_off_d      = req_off_q;
    req_size_d     = req_size_q;
    req_sgn_d      = req_sgn_q;
    req_rdest_d    = req_rdest_q;
    req_regwrite_d = req_regwrite_q;
    wb_valid_d     = 1'b0;
    wb_regwrite_d  = 1'b0;
    wb_rdest_d     = wb_rdest_q;
    wb_data_d      = wb_data_q;
    mem_req_c      = 1'b0;
    stall_c        = 1'b0;
    align_err_c    = 1'b0;
    complete_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EX_Valid) begin
          if (!ex_mem_op) begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = EX_RegWrite;
            wb_rdest_d    = EX_rDest;
            wb_data_d     = EX_ALUResult;
          end else if (!ex_aligned) begin
            // Misaligned access retires as a no-op
            align_err_c = 1'b1;
            wb_valid_d  = 1'b1;
            wb_rdest_d  = EX_rDest;
            wb_data_d   = '0;
          end else begin
            mem_req_c = 1'b1;
            if (Mem_Ack) begin
              complete_c = 1'b1;
            end else begin
              stall_c        = 1'b1;
              state_d        = ST_WAIT;
              req_addr_d     = cur_addr;
              req_we_d       = cur_we;
              req_be_d       = cur_be;
              req_wdata_d    = cur_wdata;
              req_off_d      = cur_off;
              req_size_d     = cur_size;
              req_sgn_d      = cur_sgn;
              req_rdest_d    = cur_rdest;
              req_regwrite_d = cur_regwrite;
            end
          end
        end
      end
      ST_WAIT: begin
        mem_req_c = 1'b1;
        if (Mem_Ack) begin
          complete_c = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete_c) begin
      wb_valid_d    = 1'b1;
      wb_regwrite_d = cur_regwrite & ~cur_we;
      wb_rdest_d    = cur_rdest;
      wb_data_d     = cur_we ? '0 : load_extract(Mem_RData, cur_off, cur_size, cur_sgn);
    end
  end

  always_ff @(posedge Clk) begin : state_reg
    if (Rst) begin
      state_q        <= ST_IDLE;
      req_addr_q     <= '0;
      req_we_q       <= 1'b0;
      req_be_q       <= '0;
      req_wdata_q    <= '0;
      req_off_q      <= '0;
      req_size_q     <= '0;
      req_sgn_q      <= 1'b0;
      req_rdest_q    <= '0;
      req_regwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_rdest_q     <= '0;
      wb_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      req_we_q       <= req_we_d;
      req_be_q       <= req_be_d;
      req_wdata_q    <= req_wdata_d;
      req_off_q      <= req_off_d;
      req_size_q     <= req_size_d;
      req_sgn_q      <= req_sgn_d;
      req_rdest_q    <= req_rdest_d;
      req_regwrite_q <= req_regwrite_d;
      wb_valid_q     <= wb_valid_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_rdest_q     <= wb_rdest_d;
      wb_data_q      <= wb_data_d;
    end
  end

  // Handshake and hazard outputs are forced quiet while reset is held
  assign Mem_Req  = mem_req_c & ~Rst;
  assign Stall    = stall_c & ~Rst;
  assign AlignErr = align_err_c & ~Rst;

  assign Mem_We    = cur_we;
  assign Mem_Addr  = cur_addr;
  assign Mem_WData = cur_wdata;
  assign Mem_BE    = cur_be;

  assign WB_Valid    = wb_valid_q;
  assign WB_RegWrite = wb_regwrite_q;
  assign WB_rDest    = wb_rdest_q;
  assign WB_Data     = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: per-instruction arithmetic model plus
// literal spot values, checked every cycle on the falling edge.
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        EX_Valid = 1'b0;
  logic [31:0] EX_ALUResult = '0;
  logic [31:0] EX_StoreData = '0;
  logic [4:0]  EX_rDest = '0;
  logic        EX_RegWrite = 1'b0;
  logic        EX_MemRead = 1'b0;
  logic        EX_MemWrite = 1'b0;
  logic [1:0]  EX_MemSize = 2'b10;
  logic        EX_LoadSigned = 1'b0;
  logic        Mem_Req;
  logic        Mem_We;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [3:0]  Mem_BE;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_RData = '0;
  logic        Stall;
  logic        AlignErr;
  logic        WB_Valid;
  logic        WB_RegWrite;
  logic [4:0]  WB_rDest;
  logic [31:0] WB_Data;

  mem_access_stage dut (
    .Clk(Clk), .Rst(Rst), .EX_Valid(EX_Valid), .EX_ALUResult(EX_ALUResult),
    .EX_StoreData(EX_StoreData), .EX_rDest(EX_rDest), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_MemSize(EX_MemSize),
    .EX_LoadSigned(EX_LoadSigned), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_BE(Mem_BE), .Mem_Ack(Mem_Ack),
    .Mem_RData(Mem_RData), .Stall(Stall), .AlignErr(AlignErr), .WB_Valid(WB_Valid),
    .WB_RegWrite(WB_RegWrite), .WB_rDest(WB_rDest), .WB_Data(WB_Data)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  // Model expectations for the current cycle
  logic        e_req = 1'b0, e_stall = 1'b0, e_align = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_be = '0;
  logic        e_wb_valid = 1'b0, e_wb_regwrite = 1'b0, e_wb_full = 1'b0;
  logic [4:0]  e_wb_rdest = '0;
  logic [31:0] e_wb_data = '0;

  // Observations from the most recent instruction, for literal spot checks
  logic        obs_req, obs_we, obs_align;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  int          obs_stall_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      check("mem_req", 32'(Mem_Req), 32'(e_req));
      check("stall", 32'(Stall), 32'(e_stall));
      check("align_err", 32'(AlignErr), 32'(e_align));
      if (e_req) begin
        check("mem_addr", Mem_Addr, e_addr);
        check("mem_we", 32'(Mem_We), 32'(e_we));
        check("mem_be", 32'(Mem_BE), 32'(e_be));
        if (e_we) check("mem_wdata", Mem_WData, e_wdata);
      end
      check("wb_valid", 32'(WB_Valid), 32'(e_wb_valid));
      if (e_wb_valid) begin
        check("wb_regwrite", 32'(WB_RegWrite), 32'(e_wb_regwrite));
        if (e_wb_full) begin
          check("wb_rdest", 32'(WB_rDest), 32'(e_wb_rdest));
          check("wb_data", WB_Data, e_wb_data);
        end
      end
    end
  end

  // One instruction: ack arrives ack_n cycles after the first request cycle;
  // rst_at >= 0 asserts reset in that cycle and abandons the instruction.
  task automatic run_instr(input logic valid, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rdest, input logic regw, input logic rd,
                           input logic wr, input logic [1:0] sz, input logic sgn,
                           input int ack_n, input logic [31:0] rdata, input int rst_at,
                           input logic stray_ack);
    int unsigned n, off;
    int          ncyc;
    logic        mem, aligned, req, ack;
    longint      v;
    logic [31:0] exp_load;

    off     = 32'(alu[1:0]);
    n       = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mem     = valid && (rd || wr);
    aligned = (alu % n) == 0;
    req     = mem && aligned;
    ncyc    = req ? ack_n + 1 : 1;

    v = longint'(rdata) >> (8 * off);
    v = v & ((64'd1 << (8 * n)) - 64'd1);
    if (sgn && n < 4 && v >= longint'(64'd1 << (8 * n - 1))) v = v - longint'(64'd1 << (8 * n));
    exp_load = 32'(v);

    obs_stall_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      ack           = req && (c == ack_n);
      EX_Valid      = valid;
      EX_ALUResult  = alu;
      EX_StoreData  = sd;
      EX_rDest      = rdest;
      EX_RegWrite   = regw;
      EX_MemRead    = rd;
      EX_MemWrite   = wr;
      EX_MemSize    = sz;
      EX_LoadSigned = sgn;
      Mem_Ack       = ack || stray_ack;
      Mem_RData     = ack ? rdata : $urandom();
      Rst           = (c == rst_at);
      if (Rst) begin
        e_req = 1'b0; e_stall = 1'b0; e_align = 1'b0;
      end else begin
        e_req   = req;
        e_stall = req && (c < ack_n);
        e_align = mem && !aligned;
      end
      e_addr  = alu & 32'hFFFF_FFFC;
      e_we    = wr;
      e_be    = 4'(((1 << n) - 1) << off);
      e_wdata = (n == 1) ? {24'h0, sd[7:0]} * 32'h0101_0101 :
                (n == 2) ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
      #1;
      if (c == 0) begin
        obs_req = Mem_Req; obs_we = Mem_We; obs_align = AlignErr;
        obs_addr = Mem_Addr; obs_wdata = Mem_WData; obs_be = Mem_BE;
      end
      if (Stall) obs_stall_cnt++;
      @(posedge Clk);
      #1;
      if (c == rst_at) begin
        Rst = 1'b0;
        e_wb_valid = 1'b0; e_wb_regwrite = 1'b0; e_wb_rdest = '0; e_wb_data = '0;
        break;
      end
      if (c == ncyc - 1) begin
        if (!valid) begin
          e_wb_valid = 1'b0;
        end else if (!mem) begin
          e_wb_valid = 1'b1; e_wb_regwrite = regw; e_wb_full = 1'b1;
          e_wb_rdest = rdest; e_wb_data = alu;
        end else if (!aligned) begin
          e_wb_valid = 1'b1; e_wb_regwrite = 1'b0; e_wb_full = 1'b0;
        end else begin
          e_wb_valid = 1'b1; e_wb_regwrite = regw && !wr; e_wb_full = 1'b1;
          e_wb_rdest = rdest; e_wb_data = wr ? 32'h0 : exp_load;
        end
      end else begin
        e_wb_valid = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset with a live aligned, then misaligned, memory op presented
    Rst = 1'b1;
    EX_Valid = 1'b1; EX_MemRead = 1'b1; EX_MemSize = 2'b10; EX_ALUResult = 32'h40;
    @(posedge Clk); #1;
    chk_on = 1'b1;
    @(posedge Clk); #1;
    EX_ALUResult = 32'h41;
    @(posedge Clk); #1;
    check("rst_wb_data", WB_Data, 32'h0);
    check("rst_wb_rdest", 32'(WB_rDest), 32'h0);
    check("rst_wb_regwrite", 32'(WB_RegWrite), 32'h0);
    Rst = 1'b0; EX_Valid = 1'b0; EX_MemRead = 1'b0;

    // ALU pass-through
    run_instr(1, 32'h1234, 0, 8, 1, 0, 0, 2'b10, 0, 0, 0, -1, 0);
    check("alu_data_lit", WB_Data, 32'h0000_1234);
    check("alu_rdest_lit", 32'(WB_rDest), 32'd8);
    check("alu_regwrite_lit", 32'(WB_RegWrite), 32'd1);
    check("alu_stall_lit", 32'(obs_stall_cnt), 32'd0);

    // lb, ack three cycles late
    run_instr(1, 32'h103, 0, 9, 1, 1, 0, 2'b00, 1, 3, 32'h80FF_0000, -1, 0);
    check("lb_addr_lit", obs_addr, 32'h100);
    check("lb_be_lit", 32'(obs_be), 32'h8);
    check("lb_stall_cycles_lit", 32'(obs_stall_cnt), 32'd3);
    check("lb_data_lit", WB_Data, 32'hFFFF_FF80);

    // sh, same-cycle ack (RegWrite deliberately set to exercise masking)
    run_instr(1, 32'h202, 32'hABCD_5678, 3, 1, 0, 1, 2'b01, 0, 0, 0, -1, 0);
    check("sh_be_lit", 32'(obs_be), 32'hC);
    check("sh_wdata_lit", obs_wdata, 32'h5678_5678);
    check("sh_we_lit", 32'(obs_we), 32'd1);
    check("sh_stall_lit", 32'(obs_stall_cnt), 32'd0);
    check("sh_regwrite_lit", 32'(WB_RegWrite), 32'd0);

    // lw misaligned
    run_instr(1, 32'h105, 0, 4, 1, 1, 0, 2'b10, 0, 0, 0, -1, 0);
    check("lw_mis_align_lit", 32'(obs_align), 32'd1);
    check("lw_mis_req_lit", 32'(obs_req), 32'd0);
    check("lw_mis_valid_lit", 32'(WB_Valid), 32'd1);
    check("lw_mis_regwrite_lit", 32'(WB_RegWrite), 32'd0);

    // lhu abandoned by reset in its second WAIT cycle, then a late ack
    run_instr(1, 32'h10, 0, 5, 1, 1, 0, 2'b01, 0, 5, 32'h1111_2222, 2, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, -1, 1);
    check("late_ack_req_lit", 32'(obs_req), 32'd0);
    check("late_ack_valid_lit", 32'(WB_Valid), 32'd0);
    check("late_ack_rdest_lit", 32'(WB_rDest), 32'd0);
    check("late_ack_data_lit", WB_Data, 32'h0);

    // sw then lw back to back, each acked one cycle late
    run_instr(1, 32'h300, 32'hDEAD_BEEF, 0, 0, 0, 1, 2'b10, 0, 1, 0, -1, 0);
    check("sw_be_lit", 32'(obs_be), 32'hF);
    check("sw_wdata_lit", obs_wdata, 32'hDEAD_BEEF);
    run_instr(1, 32'h300, 0, 12, 1, 1, 0, 2'b10, 0, 1, 32'hCAFE_F00D, -1, 0);
    check("lw_data_lit", WB_Data, 32'hCAFE_F00D);
    check("lw_stall_lit", 32'(obs_stall_cnt), 32'd1);

    // Lane extraction and extension variants
    run_instr(1, 32'h101, 0, 13, 1, 1, 0, 2'b00, 0, 2, 32'h1234_8765, -1, 0);
    check("lbu_data_lit", WB_Data, 32'h0000_0087);
    run_instr(1, 32'h102, 0, 14, 1, 1, 0, 2'b01, 1, 0, 32'h8001_7FFF, -1, 0);
    check("lh_data_lit", WB_Data, 32'hFFFF_8001);
    run_instr(1, 32'h102, 0, 15, 1, 1, 0, 2'b01, 0, 1, 32'h8001_7FFF, -1, 0);
    check("lhu_data_lit", WB_Data, 32'h0000_8001);
    run_instr(1, 32'h100, 0, 16, 1, 1, 0, 2'b01, 1, 0, 32'h8001_7FFF, -1, 0);
    check("lh_low_data_lit", WB_Data, 32'h0000_7FFF);

    // sb to top lane, misaligned sh, read+write treated as store
    run_instr(1, 32'h3, 32'h1234_56AB, 1, 0, 0, 1, 2'b00, 0, 2, 0, -1, 0);
    check("sb_be_lit", 32'(obs_be), 32'h8);
    check("sb_wdata_lit", obs_wdata, 32'hABAB_ABAB);
    run_instr(1, 32'h3, 32'h1234_56AB, 1, 0, 0, 1, 2'b01, 0, 0, 0, -1, 0);
    check("sh_mis_align_lit", 32'(obs_align), 32'd1);
    run_instr(1, 32'h8, 32'h0BAD_F00D, 17, 1, 1, 1, 2'b10, 0, 0, 32'h5555_5555, -1, 0);
    check("rdwr_we_lit", 32'(obs_we), 32'd1);
    check("rdwr_data_lit", WB_Data, 32'h0);

    // Reserved size behaves as word
    run_instr(1, 32'h6, 0, 18, 1, 1, 0, 2'b11, 0, 0, 0, -1, 0);
    check("sz11_mis_align_lit", 32'(obs_align), 32'd1);
    run_instr(1, 32'h8, 0, 19, 1, 1, 0, 2'b11, 1, 1, 32'h8765_4321, -1, 0);
    check("sz11_data_lit", WB_Data, 32'h8765_4321);

    // ALU right after memory op, then bubbles with a stray ack
    run_instr(1, 32'hFFFF_0001, 0, 31, 1, 0, 0, 2'b00, 0, 0, 0, -1, 0);
    run_instr(0, 32'h44, 0, 2, 1, 1, 0, 2'b10, 0, 0, 0, -1, 1);
    run_instr(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, -1, 0);

    @(negedge Clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
